input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
//
// PURPOSE
//   Conditions a raw asynchronous 1-bit input (switch/button) before it drives
//   the D input of DFlipFlop. Synchronises the input, rejects glitches shorter
//   than STABLE_CYCLES clocks, and emits a clean level plus one-cycle edge pulses.
//   It is the stage directly upstream of the flip-flop: q connects to DFlipFlop.D
//   on the same clk and reset.
//
// PARAMETERS
//   SYNC_STAGES    2  synchroniser flops on din; legal range >= 2
//   STABLE_CYCLES  4  consecutive equal synchronised samples required to accept
//                     a new level; legal range >= 2
//   Counter width is $clog2(STABLE_CYCLES+1).
//
// PORTS
//   clk      input   1  rising-edge clock, shared with DFlipFlop
//   reset    input   1  synchronous, active-high reset
//   din      input   1  raw asynchronous input; may bounce
//   q        output  1  debounced level; drives DFlipFlop.D
//   rise     output  1  one-cycle pulse when q goes 0->1
//   fall     output  1  one-cycle pulse when q goes 1->0
//   settling output  1  high while a candidate new level is being qualified
//
// BEHAVIOUR
//   - Reset, sampled on a clk rising edge while reset=1: all sync flops = 0,
//     state = LOW, cnt = 0, q = 0, rise = 0, fall = 0, settling = 0.
//     Reset overrides every other event. A qualification in progress is
//     abandoned and produces no pulse.
//   - s = last synchroniser flop, a SYNC_STAGES-deep shift chain on din.
//   - FSM states and transitions, evaluated each edge when reset = 0:
//       LOW:       q=0. If s=1: go to WAIT_HIGH, cnt=1.
//       WAIT_HIGH: q=0, settling=1.
//                  If s=0: go to LOW, cnt=0 (glitch rejected).
//                  Else if cnt==STABLE_CYCLES-1: go to HIGH, q=1, rise=1.
//                  Else cnt++.
//       HIGH:      q=1. If s=0: go to WAIT_LOW, cnt=1.
//       WAIT_LOW:  mirror of WAIT_HIGH, with settling=1. s=1 returns to HIGH.
//                  Completion goes to LOW, q=0, fall=1.
//   - All outputs are registered.
//   - rise and fall are high for exactly one cycle, in the same cycle q changes.
//     rise and fall are never high together.
//   - Latency: din changes before edge 1 and holds. q changes after edge
//     SYNC_STAGES+STABLE_CYCLES (6 with defaults).
//   - Acceptance: a din pulse lasting W edges is accepted iff W >= STABLE_CYCLES.
//     A rejected pulse leaves q unchanged and produces no pulse.
//   - Repeated bounces restart cnt from 1 on every re-entry to a WAIT state.
//     cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around.
//   - If din=1 when reset is released, the block qualifies the level normally
//     and emits rise once.
//
// TESTING
//   1 reset=1 for 3 clks with din toggling -> q=rise=fall=settling=0 throughout.
//   2 din 0->1 held (defaults) -> q=1 and rise=1 exactly after edge 6;
//     rise=0 after edge 7.
//   3 din high for 3 edges, then low -> settling pulses;
//     q stays 0, rise never asserts.
//   4 q=1, then din bounces 1,0,1,0 each edge, then 0 held -> fall asserts once,
//     6 edges after the final 1->0 change.
//   5 reset asserted in WAIT_HIGH with cnt=2 -> next edge q=0, settling=0,
//     no rise pulse.
//   6 STABLE_CYCLES=8, SYNC_STAGES=3, din step -> q changes after edge 11;
//     a 7-edge glitch is rejected.

Source files
------------

// File: rtl/input_debouncer.sv
// Input conditioner for a bouncing switch: synchroniser chain, glitch-rejecting
// qualification FSM, registered level output and one-cycle edge pulses.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic settling
);

  localparam int unsigned CntWidth = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(STABLE_CYCLES - 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  localparam logic [1:0] StLow      = 2'd0;
  localparam logic [1:0] StWaitHigh = 2'd1;
  localparam logic [1:0] StHigh     = 2'd2;
  localparam logic [1:0] StWaitLow  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [1:0]             state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   settling_q, settling_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    settling_d = 1'b0;
    case (state_q)
      StLow: begin
        q_d = 1'b0;
        if (s) begin
          state_d    = StWaitHigh;
          cnt_d      = CntOne;
          settling_d = 1'b1;
        end
      end
      StWaitHigh: begin
        q_d        = 1'b0;
        settling_d = 1'b1;
        if (!s) begin
          state_d    = StLow;
          cnt_d      = '0;
          settling_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d    = StHigh;
          cnt_d      = '0;
          q_d        = 1'b1;
          rise_d     = 1'b1;
          settling_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHigh: begin
        q_d = 1'b1;
        if (!s) begin
          state_d    = StWaitLow;
          cnt_d      = CntOne;
          settling_d = 1'b1;
        end
      end
      default: begin // StWaitLow
        q_d        = 1'b1;
        settling_d = 1'b1;
        if (s) begin
          state_d    = StHigh;
          cnt_d      = '0;
          settling_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d    = StLow;
          cnt_d      = '0;
          q_d        = 1'b0;
          fall_d     = 1'b1;
          settling_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLow;
      cnt_q      <= '0;
      q_q        <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      settling_q <= settling_d;
    end
  end

  assign q        = q_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign settling = settling_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default instance plus an 8-cycle/3-stage one.
module tb_input_debouncer;

  logic clk, reset, din, din8;
  logic q, rise, fall, settling;
  logic q8, rise8, fall8, settling8;
  int   checks = 0;
  int   errors = 0;
  int   nrise;

  input_debouncer u_dut (
    .clk(clk), .reset(reset), .din(din),
    .q(q), .rise(rise), .fall(fall), .settling(settling)
  );

  input_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(8)) u_dut8 (
    .clk(clk), .reset(reset), .din(din8),
    .q(q8), .rise(rise8), .fall(fall8), .settling(settling8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; outputs are then sampled at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    din8  = 1'b0;

    // 1: reset held with din toggling
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      tick();
      chk("t1_q", q, 1'b0);
      chk("t1_rise", rise, 1'b0);
      chk("t1_fall", fall, 1'b0);
      chk("t1_settling", settling, 1'b0);
      chk("t1_q8", q8, 1'b0);
    end
    reset = 1'b0;
    din   = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // 2: step 0->1, q and rise after edge 6
    din = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("t2_q", q, e >= 6);
      chk("t2_rise", rise, e == 6);
      chk("t2_settling", settling, (e >= 3) && (e <= 5));
    end

    // 4: bounce 0,1,0,1 then 0 held; fall 6 edges after final 1->0
    for (int e = 1; e <= 11; e++) begin
      din = (e <= 4) ? logic'(e % 2 == 0) : 1'b0;
      tick();
      chk("t4_q", q, e < 10);
      chk("t4_fall", fall, e == 10);
      chk("t4_rise", rise, 1'b0);
      chk("t4_settling", settling, (e == 3) || (e == 5) || ((e >= 7) && (e <= 9)));
    end

    // 3: 3-edge pulse rejected
    for (int e = 1; e <= 9; e++) begin
      din = (e <= 3);
      tick();
      chk("t3_q", q, 1'b0);
      chk("t3_rise", rise, 1'b0);
      chk("t3_settling", settling, (e >= 3) && (e <= 5));
    end

    // 5: reset in WAIT_HIGH with cnt=2
    din = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    chk("t5_settling_pre", settling, 1'b1);
    reset = 1'b1;
    din   = 1'b0;
    tick();
    chk("t5_q", q, 1'b0);
    chk("t5_settling", settling, 1'b0);
    chk("t5_rise", rise, 1'b0);
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("t5_post_q", q, 1'b0);
      chk("t5_post_rise", rise, 1'b0);
    end

    // din high across reset release: exactly one rise
    reset = 1'b1;
    din   = 1'b1;
    tick();
    reset = 1'b0;
    nrise = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (rise) nrise++;
      chk("rel_no_both", rise & fall, 1'b0);
    end
    chk("rel_one_rise", nrise == 1, 1'b1);
    chk("rel_q", q, 1'b1);

    // 6: STABLE_CYCLES=8, SYNC_STAGES=3
    for (int e = 1; e <= 14; e++) begin
      din8 = (e <= 7);
      tick();
      chk("t6_glitch_q8", q8, 1'b0);
      chk("t6_glitch_rise8", rise8, 1'b0);
    end
    din8 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("t6_q8", q8, e >= 11);
      chk("t6_rise8", rise8, e == 11);
      chk("t6_fall8", fall8, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
